// File: rtl/frame_uart_dumper.sv
// rtl/frame_uart_dumper.sv - streams a 4-byte header plus N RAM bytes out of an 8N1 UART TX line
module frame_uart_dumper #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_PIXELS   = 76800,
  parameter int RAM_LATENCY  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [16:0] FRAME_PIXELS,
  output logic        RD_EN,
  output logic [16:0] RD_ADDR,
  input  logic [7:0]  RD_DATA,
  output logic        TX,
  output logic        BUSY,
  output logic        DONE
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0] MAX_N = 17'(MAX_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PIXELS, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [16:0]        n_q, n_clamp;
  logic [CNT_W-1:0]   clk_cnt_q;
  logic [3:0]         bit_idx_q;
  logic [1:0]         hdr_idx_q;
  logic [16:0]        px_cnt_q;
  logic [16:0]        addr_q, fetch_addr;
  logic               rd_en_q, fetch;
  logic [RAM_LATENCY-1:0] lat_q;
  logic [RAM_LATENCY:0]   lat_all;
  logic [7:0]         pix_buf_q, shreg_q, next_byte;
  logic               tx_q;
  logic               bit_end, byte_end, load_byte, load_pix;

  assign n_clamp = (FRAME_PIXELS > MAX_N) ? MAX_N : FRAME_PIXELS;
  // lat_all[k] is high exactly k cycles after RD_EN; the top tap marks valid RD_DATA
  assign lat_all = {lat_q, rd_en_q};
  assign RD_EN   = rd_en_q;
  assign RD_ADDR = addr_q;
  assign TX      = tx_q;

  always_comb begin
    state_d    = state_q;
    load_byte  = 1'b0;
    load_pix   = 1'b0;
    next_byte  = 8'h00;
    fetch      = 1'b0;
    fetch_addr = addr_q + 17'd1;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    bit_end    = (clk_cnt_q == CNT_LAST);
    byte_end   = bit_end && (bit_idx_q == 4'd9);
    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_HEADER;
      end
      S_HEADER: begin
        BUSY = 1'b1;
        if (byte_end) begin
          if (hdr_idx_q != 2'd3) begin
            load_byte = 1'b1;
            case (hdr_idx_q)
              2'd0:    next_byte = {7'b0, n_q[16]};
              2'd1:    next_byte = n_q[15:8];
              default: next_byte = n_q[7:0];
            endcase
            // Prefetch pixel 0 while the last header byte shifts
            if (hdr_idx_q == 2'd2 && n_q != 17'd0) begin
              fetch      = 1'b1;
              fetch_addr = 17'd0;
            end
          end else if (n_q == 17'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d   = S_PIXELS;
            load_byte = 1'b1;
            load_pix  = 1'b1;
            next_byte = pix_buf_q;
            fetch     = (n_q > 17'd1);
          end
        end
      end
      S_PIXELS: begin
        BUSY = 1'b1;
        if (byte_end) begin
          if (px_cnt_q == n_q) begin
            state_d = S_FINISH;
          end else begin
            load_byte = 1'b1;
            load_pix  = 1'b1;
            next_byte = pix_buf_q;
            fetch     = ((px_cnt_q + 17'd1) < n_q);
          end
        end
      end
      S_FINISH: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      hdr_idx_q <= '0;
      px_cnt_q  <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      lat_q     <= '0;
      pix_buf_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      rd_en_q <= fetch;
      if (fetch) addr_q <= fetch_addr;
      lat_q <= lat_all[RAM_LATENCY-1:0];
      if (lat_all[RAM_LATENCY]) pix_buf_q <= RD_DATA;

      if (state_q == S_IDLE) begin
        clk_cnt_q <= '0;
        bit_idx_q <= '0;
        hdr_idx_q <= '0;
        px_cnt_q  <= '0;
        tx_q      <= 1'b1;
        if (START) begin
          n_q     <= n_clamp;
          shreg_q <= 8'hA5;
          tx_q    <= 1'b0;
        end
      end else if (state_q == S_FINISH) begin
        tx_q   <= 1'b1;
        addr_q <= '0;
      end else if (load_byte) begin
        // Next start bit begins right after the previous stop bit's last cycle
        shreg_q   <= next_byte;
        tx_q      <= 1'b0;
        bit_idx_q <= '0;
        clk_cnt_q <= '0;
        if (load_pix) px_cnt_q <= px_cnt_q + 17'd1;
        else          hdr_idx_q <= hdr_idx_q + 2'd1;
      end else if (bit_end) begin
        clk_cnt_q <= '0;
        bit_idx_q <= bit_idx_q + 4'd1;
        tx_q      <= (bit_idx_q < 4'd8) ? shreg_q[bit_idx_q[2:0]] : 1'b1;
      end else begin
        clk_cnt_q <= clk_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/frame_uart_dumper.md
# frame_uart_dumper

Read-side counterpart to the processing pipeline's RAM writer. On request, it walks the processed-image RAM (RAMProc) from address 0 and streams its contents out of a UART TX pin as 8N1 serial, preceded by a 4-byte header. It shares the RAM read port with the VGA path through an external mux; it owns that port only while BUSY is high.

## Interface
- CLKS_PER_BIT, default 434: bit period in CLK cycles (50 MHz / 115200).
- MAX_PIXELS, default 76800: largest frame length the block will send; also the RAM depth used.
- RAM_LATENCY, default 2: cycles from RD_ADDR/RD_EN to valid RD_DATA; legal values are 1 to 3.
- CLK  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-low reset.
- START  in  1  single-cycle request; sampled only in IDLE.
- FRAME_PIXELS  in  17  number of pixels to send; latched on an accepted START.
- RD_EN  out  1  RAM read strobe.
- RD_ADDR  out  17  RAM read address.
- RD_DATA  in  8  RAM read data, valid RAM_LATENCY cycles after RD_EN.
- TX  out  1  UART line; idles high.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- States: IDLE, HEADER, PIXELS, FINISH.
- IDLE: TX=1, BUSY=0, RD_EN=0, RD_ADDR=0. A START=1 moves the block to HEADER and latches the length.
  - Latched length is N = min(FRAME_PIXELS, MAX_PIXELS).
- HEADER sends 4 bytes, in order:
  - 0xA5
  - {7'b0, N[16]}
  - N[15:8]
  - N[7:0]
- After HEADER: if N=0, go straight to FINISH; otherwise go to PIXELS.
- PIXELS sends the RAM bytes at addresses 0 to N-1, in ascending order.
  - Each address is read exactly once (one RD_EN pulse per address).
  - The byte fetch for address k+1 is issued while byte k is shifting, so data is always ready before the next start bit.
- Byte framing:
  - Start bit 0, then data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Bytes are back to back: the start bit of byte n+1 follows the last stop-bit cycle of byte n, with no idle gap.
- FINISH: DONE=1 for one cycle, then return to IDLE (BUSY=0 in that same cycle).
- START while BUSY is ignored: it is not queued and does not disturb the transfer.
- RESET=0 is sampled on a clock edge. In the following cycle all of these hold, and no DONE is produced:
  - State is IDLE.
  - TX=1, BUSY=0, DONE=0, RD_EN=0, RD_ADDR=0.
  - Bit and byte counters are cleared.
  - This applies mid-byte and mid-frame alike.
- Reset values: TX=1, BUSY=0, DONE=0, RD_EN=0, RD_ADDR=0.
- Counter widths:
  - Bit-period counter: ceil(log2(CLKS_PER_BIT)) bits.
  - Bit index: 4 bits.
  - Address counter: 17 bits; it never exceeds N-1 and never wraps.
- RD_DATA is captured into a byte register at exactly RAM_LATENCY cycles after RD_EN, not later.

## Timing
- Accepted START at edge t:
  - BUSY=1 and the TX start bit of 0xA5 begin at t+1.
  - The first TX falling edge is 1 cycle after START.
- Frame duration from the first start bit to the end of the last stop bit is (4+N)·10·CLKS_PER_BIT cycles.
- DONE is asserted in the cycle immediately after the last stop-bit cycle; BUSY falls in the same cycle.
- RD_EN pulses for 1 cycle per pixel.
  - The first RD_EN (address 0) is no later than the start of the last header byte's stop bit.
  - Each later RD_EN occurs at least RAM_LATENCY+1 cycles before the start bit of the byte it feeds.
- TX is glitch-free: it is driven from a register and changes only at bit boundaries.
- A new START is accepted in the first IDLE cycle after DONE.

## Test plan
- Header only: CLKS_PER_BIT=4, FRAME_PIXELS=0.
  - TX carries A5 00 00 00 over 160 cycles.
  - DONE is asserted at cycle 161 after START.
  - No RD_EN pulses occur.
- Short frame: RAM preloaded with 0x00, 0x55, 0xFF at addresses 0–2; FRAME_PIXELS=3.
  - Decoded TX is A5 00 00 03 00 55 FF.
  - Exactly 3 RD_EN pulses, at addresses 0, 1, 2.
  - No inter-byte gap (total 280 cycles at CLKS_PER_BIT=4).
- Clamp: FRAME_PIXELS=0x1FFFF.
  - Header is A5 01 2C 00 (76800).
  - The last RD_ADDR is 76799.
- Latency sweep: run the short-frame case for RAM_LATENCY=1, 2, 3; decoded bytes are identical in all three.
- START while BUSY: pulse START mid-frame.
  - The frame is unchanged.
  - Only one DONE pulse occurs.
  - No second header is sent.
- Reset mid-byte: assert RESET=0 during the pixel byte 0x55.
  - The next cycle shows TX=1, BUSY=0, RD_ADDR=0.
  - No DONE is produced.
  - A subsequent START sends a complete, correct frame.
